// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
//   state_t              : frame-level FSM states
//   UART_DATA_WIDTH      : default data bits per frame (8N1)
//   UART_OVERSAMPLE_RATE : default sample_ticks per bit period
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH      = 8;
  localparam int unsigned UART_OVERSAMPLE_RATE = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter driven by an external 16x oversampling tick.
// Ports:
//   uart_clk    : clock, all state changes on rising edge
//   rst_n       : asynchronous active-low reset
//   sample_tick : one-cycle pulse at OVERSAMPLE_RATE x baud
//   tx_data     : byte to send, captured only on tx_valid && tx_ready
//   tx_valid    : upstream offers a byte
//   tx_ready    : high exactly while idle (decoded from state)
//   tx_serial   : registered serial line, idle high
//   tx_active   : high while a frame is in progress
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = UART_DATA_WIDTH,
  parameter int unsigned OVERSAMPLE_RATE = UART_OVERSAMPLE_RATE
) (
  input  logic                  uart_clk,
  input  logic                  rst_n,
  input  logic                  sample_tick,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_serial,
  output logic                  tx_active
);

  localparam int unsigned SCNT_W = $clog2(OVERSAMPLE_RATE);
  localparam int unsigned BCNT_W = $clog2(DATA_WIDTH);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE_RATE - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_WIDTH - 1);

  state_t                state;
  state_t                state_d;
  logic [SCNT_W-1:0]     sample_counter;
  logic [SCNT_W-1:0]     sample_counter_d;
  logic [BCNT_W-1:0]     bit_counter;
  logic [BCNT_W-1:0]     bit_counter_d;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_reg_d;
  logic                  tx_serial_d;
  logic                  bit_end;

  // Last tick of the current bit period.
  assign bit_end = sample_tick && (sample_counter == SCNT_LAST);

  assign tx_ready  = (state == IDLE);
  assign tx_active = (state != IDLE);

  // State and datapath registers.
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      sample_counter <= '0;
      bit_counter    <= '0;
      shift_reg      <= '0;
      tx_serial      <= 1'b1;
    end else begin
      state          <= state_d;
      sample_counter <= sample_counter_d;
      bit_counter    <= bit_counter_d;
      shift_reg      <= shift_reg_d;
      tx_serial      <= tx_serial_d;
    end
  end

  // Next-state and next-datapath logic. The line level is decoded from the
  // current state, so every bit appears one clock after its state is entered;
  // the shift keeps each level for exactly one full bit period.
  always_comb begin
    state_d          = state;
    sample_counter_d = sample_counter;
    bit_counter_d    = bit_counter;
    shift_reg_d      = shift_reg;
    tx_serial_d      = 1'b1;

    case (state)
      IDLE: begin
        sample_counter_d = '0;
        if (tx_valid) begin
          shift_reg_d   = tx_data;
          bit_counter_d = '0;
          state_d       = START_BIT;
        end
      end
      START_BIT: begin
        tx_serial_d = 1'b0;
        if (bit_end) begin
          state_d = DATA_BITS;
        end
      end
      DATA_BITS: begin
        tx_serial_d = shift_reg[0];
        if (bit_end) begin
          shift_reg_d   = shift_reg >> 1;
          bit_counter_d = bit_counter + BCNT_W'(1);
          if (bit_counter == BCNT_LAST) begin
            state_d = STOP_BIT;
          end
        end
      end
      STOP_BIT: begin
        if (bit_end) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Oversample counter runs only inside a frame and wraps at the bit end.
    if ((state != IDLE) && sample_tick) begin
      sample_counter_d = sample_counter + SCNT_W'(1);
    end
  end

`ifndef SYNTHESIS
  a_data_width: assert property (@(posedge uart_clk) DATA_WIDTH == 32'd8);
  a_scnt_range: assert property (@(posedge uart_clk) disable iff (!rst_n)
    32'(sample_counter) < OVERSAMPLE_RATE);
  a_idle_line:  assert property (@(posedge uart_clk) disable iff (!rst_n)
    (state == IDLE) |-> tx_serial);
  a_ready_act:  assert property (@(posedge uart_clk) tx_ready == !tx_active);
`endif

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame; only 8 is supported (8N1).
REQ-002 Parameter OVERSAMPLE_RATE, default 16, sample_ticks per bit period.
REQ-003 Port uart_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port sample_tick  input  1  one-cycle pulse at 16x baud rate, from an external generator.
REQ-006 Port tx_data  input  DATA_WIDTH  byte to transmit; sampled only on handshake.
REQ-007 Port tx_valid  input  1  upstream has a byte on tx_data.
REQ-008 Port tx_ready  output  1  transmitter can accept a byte.
REQ-009 Port tx_serial  output  1  serial line out; idle high; registered output.
REQ-010 Port tx_active  output  1  high while a frame is in progress (state != IDLE).

Function
REQ-011 Frame SHALL be 8N1: start bit (0), 8 data bits LSB first, stop bit (1); 10 bits total.
REQ-012 States SHALL be IDLE, START_BIT, DATA_BITS, STOP_BIT; no other reachable state.
REQ-013 tx_ready SHALL be 1 exactly when state == IDLE; combinational from state only, with no dependency on tx_valid.
REQ-014 Handshake: tx_valid && tx_ready at a clock edge SHALL latch tx_data into the shift register, clear sample_counter and bit_counter, and move to START_BIT.
REQ-015 tx_serial SHALL go 0 on the clock edge after the accepting edge (one-cycle latency) and SHALL hold each bit level until the next bit transition.
REQ-016 sample_counter (4 bits) SHALL increment on sample_tick outside IDLE, wrap 15->0, and be held at 0 in IDLE.
REQ-017 A bit period SHALL end on the clock where sample_tick && sample_counter == 15; each bit therefore spans 16 sample_ticks counted from state entry.
REQ-018 START_BIT -> DATA_BITS at end of bit period; tx_serial = shift_reg[0].
REQ-019 In DATA_BITS, at each end of bit period, the shift register SHALL shift right by one and bit_counter (3 bits) SHALL increment; after bit_counter == 7 completes, go to STOP_BIT with tx_serial = 1.
REQ-020 STOP_BIT -> IDLE at end of bit period; tx_serial stays 1.
REQ-021 Total frame SHALL be exactly 160 sample_ticks from the first tick after acceptance.
REQ-022 tx_data and tx_valid SHALL be ignored outside IDLE; changes to tx_data mid-frame SHALL NOT alter the frame.
REQ-023 Back-to-back: with tx_valid held high, the next byte SHALL be accepted on the first IDLE cycle; the stop bit is never shortened.
REQ-024 sample_tick with no frame in progress SHALL have no effect; missing ticks SHALL stretch the bit, never corrupt it.
REQ-025 tx_active SHALL equal (state != IDLE) every cycle.

Reset
REQ-026 On rst_n low, immediately and asynchronously: state = IDLE, tx_serial = 1, shift register = 0, counters = 0.
REQ-027 While in reset, tx_ready SHALL be 1 and tx_active SHALL be 0.
REQ-028 Reset mid-frame SHALL abort the frame with the line forced high; no partial retransmission after release.
REQ-029 The first byte SHALL be acceptable on the first clock edge after rst_n deasserts.

Structure
REQ-030 A shared package uart_pkg SHALL hold the state_t enum (IDLE, START_BIT, DATA_BITS, STOP_BIT), the DATA_WIDTH default and the OVERSAMPLE_RATE default, for common use by the receiver and transmitter.
REQ-031 The block SHALL be a single module with no sub-module; tick generation stays external.
REQ-032 The block SHALL include simulation-only assertions: DATA_WIDTH == 8, sample_counter <= 15, tx_serial == 1 in IDLE, and tx_ready == !tx_active.

Verification
REQ-033 Send 0x55 -> line shows 0,1,0,1,0,1,0,1,0,1, each level 16 ticks; tx_ready returns 1 after 160 ticks.
REQ-034 Send 0x00 then 0xFF with tx_valid held -> frames 0,00000000,1 then 0,11111111,1; second frame is accepted on the first IDLE cycle; stop bit is 16 ticks in both.
REQ-035 Change tx_data to 0x3C and pulse tx_valid mid-frame of 0xA5 -> line carries 0xA5 only; 0x3C is not accepted.
REQ-036 Assert rst_n low at tick 70 of a frame -> tx_serial = 1 and tx_ready = 1 in the same cycle; nothing is transmitted after release until a new handshake.
REQ-037 Loopback tx_serial into uart_rx through bit_sync, sending 256 random bytes -> rx_data matches each byte and frame_error stays 0.
REQ-038 Irregular sample_tick spacing (gaps of 1-5 clocks) -> bit levels are correct and each bit still spans 16 ticks.
